// File: rtl/cdc_pkg.sv
// Shared types for the req/ack clock-domain crossing.
// Holds the minimum synchroniser depth and the FSM state encodings.
package cdc_pkg;

  localparam int CDC_MIN_STAGES = 2;

  typedef enum logic [1:0] {
    M_IDLE,
    M_REQ,
    M_REL
  } m_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_VALID,
    S_ACK
  } s_state_t;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit synchroniser chain with one extra stage for edge detect.
// Ports: clk, rst (async, active-high), d, q_stages[STAGES:0] (q_stages[0] first).
module cdc_sync_bit
  import cdc_pkg::*;
#(
  parameter int STAGES = CDC_MIN_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d,
  output logic [STAGES:0]   q_stages
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_stages <= '0;
    end else begin
      q_stages <= {q_stages[STAGES-1:0], d};
    end
  end

endmodule

// File: rtl/cdc_handshake_bus.sv
// One-word valid/ready crossing from clk_m_i to clk_s_i via held data + req/ack.
// Ports: master m_data_i/m_valid_i/m_ready_o/m_done_o, slave s_data_o/s_valid_o/s_ready_i.
module cdc_handshake_bus
  import cdc_pkg::*;
#(
  parameter int          DATA_W         = 32,
  parameter int          CDC_REG_AMOUNT = 2,
  parameter int unsigned TOGGLE_MODE    = 1
) (
  input  logic              clk_m_i,
  input  logic              rst_m_i,
  input  logic              clk_s_i,
  input  logic              rst_s_i,
  input  logic [DATA_W-1:0] m_data_i,
  input  logic              m_valid_i,
  output logic              m_ready_o,
  output logic              m_done_o,
  output logic [DATA_W-1:0] s_data_o,
  output logic              s_valid_o,
  input  logic              s_ready_i
);

  localparam int N = CDC_REG_AMOUNT;

  if (N < CDC_MIN_STAGES) begin : g_bad_depth
    $error("CDC_REG_AMOUNT must be at least 2");
  end

  logic [DATA_W-1:0] m_hold;
  logic              req;
  logic              ack;
  logic [N:0]        req_q;
  logic [N:0]        ack_q;
  logic              req_s;
  logic              req_d;
  logic              ack_m;
  logic              sync_unused;

  cdc_sync_bit #(.STAGES(N)) u_req_sync (
    .clk      (clk_s_i),
    .rst      (rst_s_i),
    .d        (req),
    .q_stages (req_q)
  );

  cdc_sync_bit #(.STAGES(N)) u_ack_sync (
    .clk      (clk_m_i),
    .rst      (rst_m_i),
    .d        (ack),
    .q_stages (ack_q)
  );

  assign req_s = req_q[N-1];
  assign req_d = req_q[N];
  assign ack_m = ack_q[N-1];
  assign sync_unused = ^{req_q, ack_q};

  if (TOGGLE_MODE != 0) begin : g_tgl

    logic busy;

    always_ff @(posedge clk_m_i or posedge rst_m_i) begin
      if (rst_m_i) begin
        busy      <= 1'b0;
        req       <= 1'b0;
        m_hold    <= '0;
        m_ready_o <= 1'b0;
        m_done_o  <= 1'b0;
      end else begin
        m_done_o <= 1'b0;
        if (m_valid_i && m_ready_o) begin
          m_hold    <= m_data_i;
          req       <= ~req;
          busy      <= 1'b1;
          m_ready_o <= 1'b0;
        end else if (busy && (ack_m == req)) begin
          busy      <= 1'b0;
          m_done_o  <= 1'b1;
          m_ready_o <= 1'b1;
        end else if (!busy) begin
          m_ready_o <= 1'b1;
        end
      end
    end

    // A new req toggle cannot arrive before this word's ack
    // has returned, so consume and detect never collide.
    always_ff @(posedge clk_s_i or posedge rst_s_i) begin
      if (rst_s_i) begin
        ack       <= 1'b0;
        s_valid_o <= 1'b0;
        s_data_o  <= '0;
      end else if (s_valid_o && s_ready_i) begin
        s_valid_o <= 1'b0;
        ack       <= ~ack;
      end else if (req_s ^ req_d) begin
        s_data_o  <= m_hold;
        s_valid_o <= 1'b1;
      end
    end

  end else begin : g_lvl

    m_state_t m_st;
    s_state_t s_st;

    always_ff @(posedge clk_m_i or posedge rst_m_i) begin
      if (rst_m_i) begin
        m_st      <= M_IDLE;
        req       <= 1'b0;
        m_hold    <= '0;
        m_ready_o <= 1'b0;
        m_done_o  <= 1'b0;
      end else begin
        m_done_o <= 1'b0;
        unique case (m_st)
          M_IDLE: begin
            if (m_valid_i && m_ready_o) begin
              m_hold    <= m_data_i;
              req       <= 1'b1;
              m_ready_o <= 1'b0;
              m_st      <= M_REQ;
            end else begin
              m_ready_o <= 1'b1;
            end
          end
          M_REQ: begin
            if (ack_m) begin
              req      <= 1'b0;
              m_done_o <= 1'b1;
              m_st     <= M_REL;
            end
          end
          M_REL: begin
            if (!ack_m) begin
              m_ready_o <= 1'b1;
              m_st      <= M_IDLE;
            end
          end
          default: m_st <= M_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk_s_i or posedge rst_s_i) begin
      if (rst_s_i) begin
        s_st      <= S_IDLE;
        ack       <= 1'b0;
        s_valid_o <= 1'b0;
        s_data_o  <= '0;
      end else begin
        unique case (s_st)
          S_IDLE: begin
            if (req_s && !req_d) begin
              s_data_o  <= m_hold;
              s_valid_o <= 1'b1;
              s_st      <= S_VALID;
            end
          end
          S_VALID: begin
            if (s_ready_i) begin
              s_valid_o <= 1'b0;
              ack       <= 1'b1;
              s_st      <= S_ACK;
            end
          end
          S_ACK: begin
            if (!req_s) begin
              ack  <= 1'b0;
              s_st <= S_IDLE;
            end
          end
          default: s_st <= S_IDLE;
        endcase
      end
    end

  end

endmodule

// File: tb/tb_cdc_handshake_bus.sv
// Self-checking bench for cdc_handshake_bus in 4-phase (idx 0) and toggle (idx 1).
// Scoreboard queues compare delivered words against the words sent.
module tb_cdc_handshake_bus;

  logic clk_m = 1'b0;
  logic clk_s = 1'b0;
  logic rst_m = 1'b1;
  logic rst_s = 1'b1;
  int   tm_half = 5;
  int   ts_half = 15;

  always #(tm_half) clk_m = ~clk_m;
  always #(ts_half) clk_s = ~clk_s;

  logic [31:0] m_data  [2];
  logic        m_valid [2];
  logic        m_ready [2];
  logic        m_done  [2];
  logic [31:0] s_data  [2];
  logic        s_valid [2];
  logic        s_ready [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cdc_handshake_bus #(
      .DATA_W         (32),
      .CDC_REG_AMOUNT (2),
      .TOGGLE_MODE    (g)
    ) u_dut (
      .clk_m_i   (clk_m),
      .rst_m_i   (rst_m),
      .clk_s_i   (clk_s),
      .rst_s_i   (rst_s),
      .m_data_i  (m_data[g]),
      .m_valid_i (m_valid[g]),
      .m_ready_o (m_ready[g]),
      .m_done_o  (m_done[g]),
      .s_data_o  (s_data[g]),
      .s_valid_o (s_valid[g]),
      .s_ready_i (s_ready[g])
    );
  end

  logic [7:0] m3_data;
  logic       m3_valid;
  logic       m3_ready;
  logic       m3_done;
  logic [7:0] s3_data;
  logic       s3_valid;
  logic       s3_ready;

  cdc_handshake_bus #(
    .DATA_W         (8),
    .CDC_REG_AMOUNT (3),
    .TOGGLE_MODE    (1)
  ) u_n3 (
    .clk_m_i   (clk_m),
    .rst_m_i   (rst_m),
    .clk_s_i   (clk_s),
    .rst_s_i   (rst_s),
    .m_data_i  (m3_data),
    .m_valid_i (m3_valid),
    .m_ready_o (m3_ready),
    .m_done_o  (m3_done),
    .s_data_o  (s3_data),
    .s_valid_o (s3_valid),
    .s_ready_i (s3_ready)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] rx0[$];
  logic [31:0] rx1[$];
  int done0 = 0;
  int done1 = 0;
  longint t_rise = 0;

  always @(negedge clk_s) begin
    if (s_valid[0] && s_ready[0]) rx0.push_back(s_data[0]);
    if (s_valid[1] && s_ready[1]) rx1.push_back(s_data[1]);
  end

  always @(negedge clk_m) begin
    if (m_done[0]) done0++;
    if (m_done[1]) done1++;
  end

  always @(posedge s3_valid) t_rise = $time;

  function automatic int rx_size(input int md);
    return (md == 0) ? rx0.size() : rx1.size();
  endfunction

  function automatic logic [31:0] rx_at(input int md, input int i);
    return (md == 0) ? rx0[i] : rx1[i];
  endfunction

  function automatic int done_n(input int md);
    return (md == 0) ? done0 : done1;
  endfunction

  task automatic send(input int md, input logic [31:0] w, output bit ok);
    @(posedge clk_m);
    #1;
    m_data[md]  = w;
    m_valid[md] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_m);
      if (m_ready[md]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk_m);
    #1;
    m_valid[md] = 1'b0;
  endtask

  task automatic wait_done(input int md, input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_m);
      if (done_n(md) >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_m);
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (m_ready[md] !== 1'b0) begin
        errors++;
        $display("FAIL rst_m_ready md=%0d got %b exp 0", md, m_ready[md]);
      end
      checks++;
      if (m_done[md] !== 1'b0) begin
        errors++;
        $display("FAIL rst_m_done md=%0d got %b exp 0", md, m_done[md]);
      end
      checks++;
      if (s_valid[md] !== 1'b0) begin
        errors++;
        $display("FAIL rst_s_valid md=%0d got %b exp 0", md, s_valid[md]);
      end
      checks++;
      if (s_data[md] !== 32'h0) begin
        errors++;
        $display("FAIL rst_s_data md=%0d got %h exp 0", md, s_data[md]);
      end
    end
    @(posedge clk_m);
    #1;
    rst_m = 1'b0;
    rst_s = 1'b0;
    #1;
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (m_ready[md] !== 1'b0) begin
        errors++;
        $display("FAIL rel_m_ready md=%0d got %b exp 0", md, m_ready[md]);
      end
    end
    @(posedge clk_m);
    #1;
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (m_ready[md] !== 1'b1) begin
        errors++;
        $display("FAIL post_rst_ready md=%0d got %b exp 1", md, m_ready[md]);
      end
    end
  endtask

  task automatic test_basic(input int md);
    int n0;
    int d0;
    bit ok;
    s_ready[md] = 1'b1;
    n0 = rx_size(md);
    d0 = done_n(md);
    send(md, 32'hDEADBEEF, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept md=%0d got timeout exp accept", md);
    end
    wait_done(md, d0 + 1, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_wait md=%0d got timeout exp done", md);
    end
    repeat (30) @(negedge clk_m);
    checks++;
    if (rx_size(md) != n0 + 1) begin
      errors++;
      $display("FAIL basic_count md=%0d got %0d exp 1", md, rx_size(md) - n0);
    end else begin
      checks++;
      if (rx_at(md, n0) !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL basic_data md=%0d got %h exp deadbeef", md, rx_at(md, n0));
      end
    end
    checks++;
    if (done_n(md) != d0 + 1) begin
      errors++;
      $display("FAIL basic_done md=%0d got %0d exp 1", md, done_n(md) - d0);
    end
    checks++;
    if (m_ready[md] !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready md=%0d got %b exp 1", md, m_ready[md]);
    end
  endtask

  task automatic test_stall(input int md);
    int n0;
    int d0;
    bit ok;
    bit seen;
    s_ready[md] = 1'b0;
    n0 = rx_size(md);
    d0 = done_n(md);
    send(md, 32'hA5A5A5A5, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL stall_accept md=%0d got timeout exp accept", md);
    end
    @(posedge clk_m);
    #1;
    m_data[md]  = 32'h12345678;
    m_valid[md] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_s);
      if (s_valid[md]) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL stall_valid_wait md=%0d got timeout exp s_valid", md);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_s);
      checks++;
      if (s_valid[md] !== 1'b1 || s_data[md] !== 32'hA5A5A5A5) begin
        errors++;
        $display("FAIL stall_hold md=%0d cyc=%0d got %b/%h exp 1/a5a5a5a5",
                 md, i, s_valid[md], s_data[md]);
      end
      checks++;
      if (m_ready[md] !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready md=%0d cyc=%0d got %b exp 0", md, i, m_ready[md]);
      end
    end
    checks++;
    if (done_n(md) != d0) begin
      errors++;
      $display("FAIL stall_no_done md=%0d got %0d exp 0", md, done_n(md) - d0);
    end
    @(posedge clk_m);
    #1;
    m_valid[md] = 1'b0;
    @(posedge clk_s);
    #1;
    s_ready[md] = 1'b1;
    wait_done(md, d0 + 1, ok);
    repeat (30) @(negedge clk_m);
    checks++;
    if (rx_size(md) != n0 + 1) begin
      errors++;
      $display("FAIL stall_count md=%0d got %0d exp 1", md, rx_size(md) - n0);
    end else begin
      checks++;
      if (rx_at(md, n0) !== 32'hA5A5A5A5) begin
        errors++;
        $display("FAIL stall_data md=%0d got %h exp a5a5a5a5", md, rx_at(md, n0));
      end
    end
    checks++;
    if (m_ready[md] !== 1'b1) begin
      errors++;
      $display("FAIL stall_ready_end md=%0d got %b exp 1", md, m_ready[md]);
    end
  endtask

  task automatic test_reset_mid();
    int n0[2];
    int d0[2];
    bit ok0;
    bit ok1;
    for (int md = 0; md < 2; md++) begin
      s_ready[md] = 1'b1;
      n0[md] = rx_size(md);
      d0[md] = done_n(md);
    end
    fork
      send(0, 32'hBAD0BAD0, ok0);
      send(1, 32'hBAD1BAD1, ok1);
    join
    rst_m = 1'b1;
    rst_s = 1'b1;
    checks++;
    if ((ok0 & ok1) !== 1'b1) begin
      errors++;
      $display("FAIL mid_accept got %b%b exp 11", ok0, ok1);
    end
    repeat (5) @(posedge clk_s);
    #1;
    rst_m = 1'b0;
    rst_s = 1'b0;
    repeat (40) @(negedge clk_m);
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (rx_size(md) != n0[md]) begin
        errors++;
        $display("FAIL mid_spurious_valid md=%0d got %0d exp 0", md, rx_size(md) - n0[md]);
      end
      checks++;
      if (done_n(md) != d0[md]) begin
        errors++;
        $display("FAIL mid_spurious_done md=%0d got %0d exp 0", md, done_n(md) - d0[md]);
      end
      checks++;
      if (m_ready[md] !== 1'b1) begin
        errors++;
        $display("FAIL mid_ready md=%0d got %b exp 1", md, m_ready[md]);
      end
    end
    fork
      send(0, 32'h1, ok0);
      send(1, 32'h1, ok1);
    join
    wait_done(0, d0[0] + 1, ok0);
    wait_done(1, d0[1] + 1, ok1);
    repeat (30) @(negedge clk_m);
    for (int md = 0; md < 2; md++) begin
      checks++;
      if (rx_size(md) != n0[md] + 1) begin
        errors++;
        $display("FAIL mid_next_count md=%0d got %0d exp 1", md, rx_size(md) - n0[md]);
      end else begin
        checks++;
        if (rx_at(md, n0[md]) !== 32'h1) begin
          errors++;
          $display("FAIL mid_next_data md=%0d got %h exp 1", md, rx_at(md, n0[md]));
        end
      end
    end
  endtask

  task automatic test_random(input int md, input int n);
    logic [31:0] exp_q[$];
    logic [31:0] w;
    int n0;
    int d0;
    int got;
    bit ok;
    s_ready[md] = 1'b1;
    n0 = rx_size(md);
    d0 = done_n(md);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      send(md, w, ok);
      checks++;
      if (ok !== 1'b1) begin
        errors++;
        $display("FAIL rand_accept md=%0d word=%0d got timeout exp accept", md, i);
        break;
      end
      exp_q.push_back(w);
    end
    wait_done(md, d0 + exp_q.size(), ok);
    repeat (30) @(negedge clk_m);
    got = rx_size(md) - n0;
    checks++;
    if (got != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count md=%0d got %0d exp %0d", md, got, exp_q.size());
    end
    checks++;
    if (done_n(md) - d0 != exp_q.size()) begin
      errors++;
      $display("FAIL rand_done md=%0d got %0d exp %0d", md, done_n(md) - d0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got; i++) begin
      checks++;
      if (rx_at(md, n0 + i) !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_data md=%0d idx=%0d got %h exp %h",
                 md, i, rx_at(md, n0 + i), exp_q[i]);
      end
    end
  endtask

  task automatic test_latency();
    logic [7:0] b;
    longint t0;
    longint lat;
    longint lo;
    longint hi;
    bit ok;
    s3_ready = 1'b1;
    lo = 3 * 2 * ts_half;
    hi = 2 * tm_half + 5 * 2 * ts_half;
    for (int it = 0; it < 4; it++) begin
      repeat (it) @(posedge clk_m);
      b = 8'($urandom);
      @(posedge clk_m);
      #1;
      m3_data  = b;
      m3_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk_m);
        if (m3_ready) begin
          ok = 1'b1;
          break;
        end
      end
      @(posedge clk_m);
      t0 = $time;
      #1;
      m3_valid = 1'b0;
      checks++;
      if (ok !== 1'b1) begin
        errors++;
        $display("FAIL lat_accept it=%0d got timeout exp accept", it);
      end
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk_s);
        if (s3_valid) begin
          ok = 1'b1;
          break;
        end
      end
      checks++;
      if (ok !== 1'b1) begin
        errors++;
        $display("FAIL lat_valid_wait it=%0d got timeout exp s_valid", it);
      end else begin
        lat = t_rise - t0;
        checks++;
        if (lat <= lo || lat > hi) begin
          errors++;
          $display("FAIL lat_range it=%0d got %0d exp (%0d,%0d]", it, lat, lo, hi);
        end
        checks++;
        if (s3_data !== b) begin
          errors++;
          $display("FAIL lat_data it=%0d got %h exp %h", it, s3_data, b);
        end
      end
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk_m);
        if (m3_done) begin
          ok = 1'b1;
          break;
        end
      end
      checks++;
      if (ok !== 1'b1) begin
        errors++;
        $display("FAIL lat_done it=%0d got timeout exp m_done", it);
      end
    end
  endtask

  initial begin
    for (int md = 0; md < 2; md++) begin
      m_data[md]  = '0;
      m_valid[md] = 1'b0;
      s_ready[md] = 1'b0;
    end
    m3_data  = '0;
    m3_valid = 1'b0;
    s3_ready = 1'b0;

    test_reset();
    for (int md = 0; md < 2; md++) begin
      test_basic(md);
      test_stall(md);
    end
    test_reset_mid();

    tm_half = 5;
    ts_half = 15;
    fork
      test_random(0, 500);
      test_random(1, 500);
    join

    tm_half = 15;
    ts_half = 5;
    repeat (4) @(posedge clk_m);
    fork
      test_random(0, 500);
      test_random(1, 500);
    join

    tm_half = 5;
    ts_half = 15;
    repeat (4) @(posedge clk_s);
    test_latency();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
